bit_serializer: RTL
===================

Name: bit_serializer

Overview:
- Parallel-to-serial converter. Accepts one C_DATA_WIDTH-bit word on a valid/ready handshake and emits it one bit per enabled clock on a single-bit stream.
- The stream carries bit_valid and bit_last qualifiers.
- Sits upstream of the single-bit delay/alignment shift registers and serial links. It is the transmit end of the bit-serial path whose receive end shifts data_in into a register.

Parameters:
- C_DATA_WIDTH, 16, word width in bits; legal range 2..64.
- C_MSB_FIRST, 1, 1 = emit word_in[C_DATA_WIDTH-1] first; 0 = emit word_in[0] first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  clock enable; all state advances only on cycles with ce=1.
- word_in  input  C_DATA_WIDTH  parallel word to serialize.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  block can accept word_in this cycle.
- bit_out  output  1  current serial bit.
- bit_valid  output  1  bit_out is a live frame bit.
- bit_last  output  1  bit_out is the final bit of the frame.
- busy  output  1  frame in progress (equals bit_valid).

Behaviour:
- Reset: asynchronous, active-high.
  - bit_out=0, bit_valid=0, bit_last=0, busy=0, word_ready=0 while rst=1.
  - State returns to IDLE, bit counter=0, shift register=0.
- States: IDLE and SHIFT.
- Accept: handshake fires on a rising edge where word_valid=1, word_ready=1 and ce=1.
- word_ready (combinational) = ce AND (state==IDLE OR (state==SHIFT AND bit_last)).
  - word_ready never depends on word_valid.
- On accept:
  - word_in is loaded into the shift register; counter=0; state becomes SHIFT.
  - The first bit appears on bit_out with bit_valid=1 from the cycle after the accept edge. Latency is 1 cycle.
- In SHIFT, each ce=1 edge:
  - The register shifts by one. It shifts left when C_MSB_FIRST=1 and right when C_MSB_FIRST=0; the vacated bit is filled with 0.
  - The counter increments.
- bit_out is the register's MSB when C_MSB_FIRST=1, and its LSB otherwise.
- bit_last=1 when counter==FRAME_LEN-1. FRAME_LEN=C_DATA_WIDTH without the optional feature.
- End of frame, on a ce=1 edge with bit_last=1:
  - If a new word is accepted on the same edge: reload, counter=0, stay in SHIFT. This gives back-to-back frames with zero bubble cycles.
  - Otherwise: go to IDLE, bit_valid=0, bit_out=0.
- ce=0 freezes everything:
  - bit_out, bit_valid, bit_last, counter and state hold.
  - word_ready=0, so no accept is possible.
  - The downstream consumer samples a bit only on cycles with bit_valid=1 AND ce=1.
- Counter width is clog2(FRAME_LEN). The counter never exceeds FRAME_LEN-1; there is no wrap inside a frame.
- word_valid=1 in SHIFT before the last bit: not accepted. The word must be held by the source until word_ready=1.
- Reset mid-frame: the frame is aborted immediately. No further bits are emitted, and bit_last is not produced for the aborted frame.
- Throughput: one word per FRAME_LEN enabled cycles.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined:
  - FRAME_LEN = C_DATA_WIDTH+1.
  - After the last data bit, one extra bit is emitted: even parity (XOR-reduce) of the accepted word, captured at accept time.
  - bit_last asserts on the parity bit, not on the last data bit.
  - word_ready's end-of-frame term uses that parity-bit cycle.
- Not defined:
  - FRAME_LEN = C_DATA_WIDTH.
  - No parity register or logic is present, and bit_last marks the last data bit.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, release, word_valid=0 for 10 cycles, ce=1 -> bit_valid=0, bit_out=0, word_ready=1 after reset release.
- Single word, MSB first: C_DATA_WIDTH=8, word_in=8'hA5 accepted with ce=1 -> next 8 cycles bit_out=1,0,1,0,0,1,0,1, bit_valid=1 throughout, bit_last=1 only on the 8th cycle, then bit_valid=0.
- Back-to-back, LSB first: C_MSB_FIRST=0, words 8'h01 then 8'h80 with word_valid held high -> 16 contiguous valid cycles: 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1. word_ready=1 exactly on each bit_last cycle; no gap between frames.
- ce stall: word 8'hF0, ce=0 for 3 cycles after the 2nd bit -> bit_out holds 1 and the counter holds during the stall, word_ready=0. The remaining 6 bits follow once ce=1; total 8 bits.
- Mid-frame reset: rst pulsed asynchronously during the 4th bit of 8'hFF -> bit_valid drops immediately and stays 0. No bit_last is seen. The next accepted word 8'h3C serializes correctly from its first bit.
- Parity (BIT_SERIALIZER_PARITY_EN defined): word 8'h07, MSB first -> 9 bits 0,0,0,0,0,1,1,1,1 with bit_last on the 9th. Word 8'h03 -> 9th bit=0.

Source files
------------

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle for bit_serializer.
// The source/consumer side uses master; the serializer uses slave.
interface bit_serializer_if #(
    parameter int C_DATA_WIDTH = 16
) ();
    // Handshake: a word transfers on a rising clk edge where word_valid and word_ready
    // are both 1. word_ready never depends on word_valid. The source holds word_in
    // stable until the transfer happens. The consumer takes a bit only on cycles
    // with bit_valid=1 and ce=1.
    logic [C_DATA_WIDTH-1:0] word_in;
    logic                    word_valid;
    logic                    word_ready;
    logic                    bit_out;
    logic                    bit_valid;
    logic                    bit_last;
    logic                    busy;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready,
        input  bit_out,
        input  bit_valid,
        input  bit_last,
        input  busy
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready,
        output bit_out,
        output bit_valid,
        output bit_last,
        output busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one word per frame, one bit per enabled clock.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer #(
    parameter int C_DATA_WIDTH = 16,
    parameter bit C_MSB_FIRST  = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    bit_serializer_if.slave s,
    output logic           state_dbg
);
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = C_DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = C_DATA_WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [C_DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]        cnt;
    logic                    last_bit;
    logic                    accept;
    logic                    data_bit;

    assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);
    // Ready is forced low under reset because the async reset already parks state in IDLE.
    assign s.word_ready = !rst && ce && ((state == IDLE) || last_bit);
    assign accept       = s.word_valid && s.word_ready;
    assign data_bit     = C_MSB_FIRST ? shift_reg[C_DATA_WIDTH-1] : shift_reg[0];

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(C_DATA_WIDTH);
    logic parity_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (ce && accept) begin
            parity_reg <= ^s.word_in;
        end
    end

    assign s.bit_out = (state == SHIFT) && ((cnt == PAR_CNT) ? parity_reg : data_bit);
`else
    assign s.bit_out = (state == SHIFT) && data_bit;
`endif

    assign s.bit_valid = (state == SHIFT);
    assign s.bit_last  = last_bit;
    assign s.busy      = (state == SHIFT);
    assign state_dbg   = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ce) begin
            unique case (state)
                IDLE:    if (accept) state_nxt = SHIFT;
                SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt       <= '0;
        end else if (ce) begin
            if (accept) begin
                shift_reg <= s.word_in;
                cnt       <= '0;
            end else if (state == SHIFT) begin
                // Zero fill keeps the register empty once the data bits are gone.
                shift_reg <= C_MSB_FIRST ? {shift_reg[C_DATA_WIDTH-2:0], 1'b0}
                                         : {1'b0, shift_reg[C_DATA_WIDTH-1:1]};
                cnt       <= last_bit ? '0 : cnt + CNT_W'(1);
            end
        end
    end
endmodule
